// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/busy/done handshake.
// Single-cycle ops complete one cycle after the accept edge.
// Defining ALU_MULDIV_EN adds iterative MUL/DIVU/REMU (WIDTH+1 cycle latency).
// Without it, those opcodes execute ADD and busy_o is tied low.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  // Returns {ovf, result}; unlisted opcodes fall through to ADD.
  function automatic logic [WIDTH:0] alu_single(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    logic [SHW-1:0]          sh;
    logic                    v;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    v  = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = WIDTH'(sa >>> sh);
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SUB: begin
        r = a - b;
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        r = a + b;
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
    return {v, r};
  endfunction

  logic [WIDTH:0] single;
  assign single = alu_single(ctrl_i, src1_i, src2_i);

`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1110;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam int         CNT_W   = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  // part: product accumulator / partial remainder
  // mcnd: shifting multiplicand / divisor
  // quot: shifting multiplier / dividend turning into quotient
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] mcnd;
  logic [WIDTH-1:0] quot;
  logic             want_rem;
  logic [WIDTH-1:0] mul_nx;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] fin;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             last;

  assign busy_o = (state != ST_IDLE);
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  // Next values for one shift-add multiply step and one restoring-divide step
  always_comb begin
    mul_nx = quot[0] ? (part + mcnd) : part;
    trial  = {part, quot[WIDTH-1]};
    diff   = trial - {1'b0, mcnd};
    rem_nx = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx = {quot[WIDTH-2:0], ~diff[WIDTH]};
    fin    = (state == ST_MUL) ? mul_nx : (want_rem ? rem_nx : quo_nx);
  end

  // Capture operands on accept, then advance one iteration per cycle
  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE) begin
      if (start_i) begin
        part     <= '0;
        mcnd     <= (ctrl_i == OP_MUL) ? src1_i : src2_i;
        quot     <= (ctrl_i == OP_MUL) ? src2_i : src1_i;
        want_rem <= (ctrl_i == OP_REMU);
      end
    end else if (state == ST_MUL) begin
      part <= mul_nx;
      mcnd <= mcnd << 1;
      quot <= quot >> 1;
    end else begin
      part <= rem_nx;
      quot <= quo_nx;
    end
  end

  // Handshake FSM and registered result/flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      done_o   <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b1;
      ovf_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            cnt <= '0;
            if (ctrl_i == OP_MUL) begin
              state <= ST_MUL;
            end else if ((ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU)) begin
              state <= ST_DIV;
            end else begin
              result_o <= single[WIDTH-1:0];
              ovf_o    <= single[WIDTH];
              zero_o   <= (single[WIDTH-1:0] == '0);
              done_o   <= 1'b1;
            end
          end
        end
        default: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state    <= ST_IDLE;
            result_o <= fin;
            ovf_o    <= 1'b0;
            zero_o   <= (fin == '0);
            done_o   <= 1'b1;
          end
        end
      endcase
    end
  end
`else
  assign busy_o = 1'b0;

  // Every opcode completes one cycle after the accept edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      done_o   <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b1;
      ovf_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        result_o <= single[WIDTH-1:0];
        ovf_o    <= single[WIDTH];
        zero_o   <= (single[WIDTH-1:0] == '0);
        done_o   <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=32) against
// an arithmetic reference model. Honors ALU_MULDIV_EN like the design.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl = 4'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        ovf;

  int errs = 0;
  int checks = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .start_i (start),
    .ctrl_i  (ctrl),
    .src1_i  (src1),
    .src2_i  (src2),
    .busy_o  (busy),
    .done_o  (done),
    .result_o(result),
    .zero_o  (zero),
    .ovf_o   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_md(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
    return (op == 4'b1010) || (op == 4'b1011) || (op == 4'b1110);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: {ovf, result} from plain integer arithmetic
  function automatic logic [32:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa;
    longint sb;
    longint s;
    longint p;
    logic [63:0] prod;
    logic [31:0] r;
    logic v;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    p  = longint'(64'd1 << sh);
    v  = 1'b0;
    r  = 32'd0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b0100: begin prod = {32'd0, a} * 64'(p); r = prod[31:0]; end
      4'b0101: r = 32'(longint'({32'd0, a}) / p);
      4'b1101: begin
        if (sa < 0) s = -((-sa - 1) / p) - 1;
        else        s = sa / p;
        r = s[31:0];
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: r = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      4'b0110: begin
        s = sa - sb;
        r = s[31:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: begin
        if (is_md(op)) begin
          if (op == 4'b1010) begin
            prod = {32'd0, a} * {32'd0, b};
            r = prod[31:0];
          end else if (op == 4'b1011) begin
            r = (b == 0) ? 32'hFFFF_FFFF : a / b;
          end else begin
            r = (b == 0) ? a : a % b;
          end
        end else begin
          s = sa + sb;
          r = s[31:0];
          v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
      end
    endcase
    return {v, r};
  endfunction

  // Issue one op at posedge+1, wait for done (bounded), check everything
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [32:0] e;
    int lat;
    int n;
    e   = ref_op(op, a, b);
    lat = is_md(op) ? 33 : 1;
    ctrl = op; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'(lat > 1));
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"}, 64'(result), 64'(e[31:0]));
    check({tag, "_zero"}, 64'(zero), 64'(e[31:0] == 32'd0));
    check({tag, "_ovf"}, 64'(ovf), 64'(e[32]));
    check({tag, "_idle"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [32:0] e;
    int n;
    int spur;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_res", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed overflow on ADD
    do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1);

    // Back-to-back SUB, SLT, SLTU
    ctrl = 4'b0110; src1 = 32'd5; src2 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    check("b2b_sub_done", 64'(done), 64'd1);
    check("b2b_sub_res", 64'(result), 64'd0);
    check("b2b_sub_zero", 64'(zero), 64'd1);
    ctrl = 4'b0111; src1 = 32'hFFFF_FFFF; src2 = 32'd1;
    @(posedge clk); #1;
    check("b2b_slt_done", 64'(done), 64'd1);
    check("b2b_slt_res", 64'(result), 64'(ref_op(4'b0111, 32'hFFFF_FFFF, 32'd1)));
    ctrl = 4'b1000;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_sltu_done", 64'(done), 64'd1);
    check("b2b_sltu_res", 64'(result), 64'(ref_op(4'b1000, 32'hFFFF_FFFF, 32'd1)));
    check("b2b_sltu_zero", 64'(zero), 64'd1);
    @(posedge clk); #1;
    check("b2b_pulse", 64'(done), 64'd0);

    // Shifts use only the low five bits of src2
    do_op("sra", 4'b1101, 32'h8000_0000, 32'h24);
    check("sra_val", 64'(result), 64'h0000_0000_F800_0000);
    do_op("srl", 4'b0101, 32'h8000_0000, 32'h24);
    check("srl_val", 64'(result), 64'h0000_0000_0800_0000);

    // MUL with a start pulse in the middle that must be ignored
    e = ref_op(4'b1010, 32'h10001, 32'h10001);
    ctrl = 4'b1010; src1 = 32'h10001; src2 = 32'h10001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    if (is_md(4'b1010)) begin
      repeat (10) begin @(posedge clk); #1; n++; end
      ctrl = 4'b0010; src1 = 32'd7; src2 = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      check("mul_busy_mid", 64'(busy), 64'd1);
    end
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mul_lat", 64'(n), 64'(is_md(4'b1010) ? 33 : 1));
    check("mul_res", 64'(result), 64'(e[31:0]));
    @(posedge clk); #1;
    check("mul_pulse", 64'(done), 64'd0);
    check("mul_no_extra", 64'(busy), 64'd0);

    // Division and divide-by-zero
    do_op("divu", 4'b1011, 32'd100, 32'd7);
    do_op("remu", 4'b1110, 32'd100, 32'd7);
    do_op("divu0", 4'b1011, 32'd9, 32'd0);
    do_op("remu0", 4'b1110, 32'd9, 32'd0);

    // Reset in the middle of a DIVU
    ctrl = 4'b1011; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_res", 64'(result), 64'd0);
    check("mrst_zero", 64'(zero), 64'd1);
    check("mrst_ovf", 64'(ovf), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    spur = 0;
    repeat (40) begin
      if (done || busy) spur++;
      @(posedge clk); #1;
    end
    check("mrst_quiet", 64'(spur), 64'd0);
    do_op("post_rst_add", 4'b0010, 32'd2, 32'd3);

    // Randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(0, 3));
        1: ra = 32'h7FFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op($sformatf("rnd%0d_op%0h", i, rop), rop, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
